// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the FFN systolic tile controller.
//   - default operand/accumulator widths and reduction-length limit
//   - sequencer state encoding
//   - PE-index to result-slot mapping inside the packed result word
//   - helper that clamps a requested reduction length
package systolic_pkg;

  localparam int MAC_WIDTH_DEF = 9;
  localparam int ACC_WIDTH_DEF = 37;
  localparam int K_MAX_DEF     = 16;

  // Result word slot for each PE accumulator (C00, C01, C10, C11).
  localparam int SLOT_C00 = 0;
  localparam int SLOT_C01 = 1;
  localparam int SLOT_C10 = 2;
  localparam int SLOT_C11 = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESULT  = 3'd5
  } seq_state_t;

  // Requested reduction lengths above the array limit run at the limit.
  function automatic int unsigned clamp_k(input int unsigned k, input int unsigned k_max);
    if (k > k_max) begin
      return k_max;
    end else begin
      return k;
    end
  endfunction

endpackage

// File: rtl/skew_reg.sv
// skew_reg: one-element delay register for a lane-1 PE edge operand.
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : load d_i (one array step)
//   clr_i    : synchronous zero, takes priority over en_i
//   d_i      : operand to delay
//   q_o      : delayed operand
module skew_reg
  import systolic_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: zero on clear, new operand on a step, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = {WIDTH{1'b0}};
    end else if (en_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // Storage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pe_tile_sequencer.sv
// pe_tile_sequencer: runs one 2x2 PE tile through C = A*B of length K.
//   start_i/cfg_k_i            : job start and reduction length (IDLE only)
//   busy_o                     : job in progress
//   a_*/b_* streams            : A column {A1,A0} and B row {B1,B0} per step
//   pe_a_*/pe_b_*              : skewed PE edge operands (lane 1 one step late)
//   pe_acc_en_o / pe_clr_o     : PE step enable and accumulator clear
//   pe_acc_0..3_i              : PE accumulators C00, C01, C10, C11
//   res_* stream               : captured {C11, C10, C01, C00}
//   done_o                     : one-cycle pulse after the result handshake
module pe_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int MAC_WIDTH = MAC_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int K_MAX     = K_MAX_DEF,
  parameter int CNT_W     = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       cfg_k_i,
  output logic                   busy_o,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [2*MAC_WIDTH-1:0] a_data_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [2*MAC_WIDTH-1:0] b_data_i,
  output logic [MAC_WIDTH-1:0]   pe_a_0_o,
  output logic [MAC_WIDTH-1:0]   pe_a_1_o,
  output logic [MAC_WIDTH-1:0]   pe_b_0_o,
  output logic [MAC_WIDTH-1:0]   pe_b_1_o,
  output logic                   pe_acc_en_o,
  output logic                   pe_clr_o,
  input  logic [ACC_WIDTH-1:0]   pe_acc_0_i,
  input  logic [ACC_WIDTH-1:0]   pe_acc_1_i,
  input  logic [ACC_WIDTH-1:0]   pe_acc_2_i,
  input  logic [ACC_WIDTH-1:0]   pe_acc_3_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [4*ACC_WIDTH-1:0] res_data_o,
  output logic                   done_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_t             state_q;
  logic [CNT_W-1:0]       k_q;
  logic [CNT_W-1:0]       step_q;
  logic                   busy_q;
  logic                   res_valid_q;
  logic                   done_q;
  logic [4*ACC_WIDTH-1:0] res_data_q;

  logic                   in_feed;
  logic                   in_drain;
  logic                   joint_xfer;
  logic                   step_en;
  logic                   skew_clr;
  logic [MAC_WIDTH-1:0]   skew_a;
  logic [MAC_WIDTH-1:0]   skew_b;

  assign in_feed    = (state_q == ST_FEED);
  assign in_drain   = (state_q == ST_DRAIN);
  // A and B are consumed only as a pair; each pair is one array step.
  assign joint_xfer = in_feed & a_valid_i & b_valid_i;
  assign step_en    = joint_xfer | in_drain;
  // Zero the skew at job start, and during drain so the second drain step sees 0.
  assign skew_clr   = (state_q == ST_CLEAR) | in_drain;

  assign a_ready_o   = joint_xfer;
  assign b_ready_o   = joint_xfer;
  assign pe_acc_en_o = step_en;
  assign pe_clr_o    = (state_q == ST_CLEAR);
  assign busy_o      = busy_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign done_o      = done_q;

  skew_reg #(.WIDTH(MAC_WIDTH)) u_skew_a (
    .clk   (clk),
    .rst   (rst),
    .en_i  (joint_xfer),
    .clr_i (skew_clr),
    .d_i   (a_data_i[2*MAC_WIDTH-1:MAC_WIDTH]),
    .q_o   (skew_a)
  );

  skew_reg #(.WIDTH(MAC_WIDTH)) u_skew_b (
    .clk   (clk),
    .rst   (rst),
    .en_i  (joint_xfer),
    .clr_i (skew_clr),
    .d_i   (b_data_i[2*MAC_WIDTH-1:MAC_WIDTH]),
    .q_o   (skew_b)
  );

  // PE edge operands: lane 0 live from the streams, lane 1 from the skew registers.
  always_comb begin
    pe_a_0_o = {MAC_WIDTH{1'b0}};
    pe_b_0_o = {MAC_WIDTH{1'b0}};
    pe_a_1_o = {MAC_WIDTH{1'b0}};
    pe_b_1_o = {MAC_WIDTH{1'b0}};
    if (joint_xfer) begin
      pe_a_0_o = a_data_i[MAC_WIDTH-1:0];
      pe_b_0_o = b_data_i[MAC_WIDTH-1:0];
    end else begin
      pe_a_0_o = {MAC_WIDTH{1'b0}};
      pe_b_0_o = {MAC_WIDTH{1'b0}};
    end
    if (step_en) begin
      pe_a_1_o = skew_a;
      pe_b_1_o = skew_b;
    end else begin
      pe_a_1_o = {MAC_WIDTH{1'b0}};
      pe_b_1_o = {MAC_WIDTH{1'b0}};
    end
  end

  // Job sequencer: state, step counter, result capture and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= CNT_ZERO;
      step_q      <= CNT_ZERO;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      res_data_q  <= {(4*ACC_WIDTH){1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            k_q     <= CNT_W'(clamp_k(32'(cfg_k_i), K_MAX));
            step_q  <= CNT_ZERO;
            busy_q  <= 1'b1;
            state_q <= ST_CLEAR;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          // K = 0 has nothing to feed; the cleared accumulators are the result.
          if (k_q == CNT_ZERO) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (joint_xfer) begin
            if (step_q == (k_q - CNT_ONE)) begin
              step_q  <= CNT_ZERO;
              state_q <= ST_DRAIN;
            end else begin
              step_q <= step_q + CNT_ONE;
            end
          end else begin
            step_q <= step_q;
          end
        end
        ST_DRAIN: begin
          // Two flush steps push the skewed lane-1 tail through PE(1,1).
          if (step_q == CNT_ONE) begin
            step_q  <= CNT_ZERO;
            state_q <= ST_CAPTURE;
          end else begin
            step_q <= step_q + CNT_ONE;
          end
        end
        ST_CAPTURE: begin
          res_data_q[SLOT_C00*ACC_WIDTH +: ACC_WIDTH] <= pe_acc_0_i;
          res_data_q[SLOT_C01*ACC_WIDTH +: ACC_WIDTH] <= pe_acc_1_i;
          res_data_q[SLOT_C10*ACC_WIDTH +: ACC_WIDTH] <= pe_acc_2_i;
          res_data_q[SLOT_C11*ACC_WIDTH +: ACC_WIDTH] <= pe_acc_3_i;
          res_valid_q <= 1'b1;
          state_q     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_RESULT;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          step_q      <= CNT_ZERO;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Testbench for pe_tile_sequencer with a behavioural 2x2 output-stationary
// PE tile closing the loop between the edge operands and the accumulators.
module tb_pe_tile_sequencer;

  localparam int MW    = 9;
  localparam int AW    = 37;
  localparam int K_MAX = 16;
  localparam int CW    = 5;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic [CW-1:0]   cfg_k_i;
  logic            busy_o;
  logic            a_valid_i, a_ready_o, b_valid_i, b_ready_o;
  logic [2*MW-1:0] a_data_i, b_data_i;
  logic [MW-1:0]   pe_a_0_o, pe_a_1_o, pe_b_0_o, pe_b_1_o;
  logic            pe_acc_en_o, pe_clr_o;
  logic [AW-1:0]   pe_acc_0_i, pe_acc_1_i, pe_acc_2_i, pe_acc_3_i;
  logic            res_valid_o, res_ready_i;
  logic [4*AW-1:0] res_data_o;
  logic            done_o;

  int n_checks = 0;
  int n_fail   = 0;

  pe_tile_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_k_i(cfg_k_i), .busy_o(busy_o),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
    .pe_a_0_o(pe_a_0_o), .pe_a_1_o(pe_a_1_o), .pe_b_0_o(pe_b_0_o), .pe_b_1_o(pe_b_1_o),
    .pe_acc_en_o(pe_acc_en_o), .pe_clr_o(pe_clr_o),
    .pe_acc_0_i(pe_acc_0_i), .pe_acc_1_i(pe_acc_1_i),
    .pe_acc_2_i(pe_acc_2_i), .pe_acc_3_i(pe_acc_3_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE tile: A flows right, B flows down, each PE accumulates a*b.
  logic signed [MW-1:0] m_a00, m_b00, m_a10, m_b01;
  logic signed [AW-1:0] m_acc00, m_acc01, m_acc10, m_acc11;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || pe_clr_o) begin
      m_a00 <= '0; m_b00 <= '0; m_a10 <= '0; m_b01 <= '0;
      m_acc00 <= '0; m_acc01 <= '0; m_acc10 <= '0; m_acc11 <= '0;
    end else if (pe_acc_en_o) begin
      m_acc00 <= m_acc00 + $signed(pe_a_0_o) * $signed(pe_b_0_o);
      m_acc01 <= m_acc01 + m_a00 * $signed(pe_b_1_o);
      m_acc10 <= m_acc10 + $signed(pe_a_1_o) * m_b00;
      m_acc11 <= m_acc11 + m_a10 * m_b01;
      m_a00 <= $signed(pe_a_0_o);
      m_b00 <= $signed(pe_b_0_o);
      m_a10 <= $signed(pe_a_1_o);
      m_b01 <= $signed(pe_b_1_o);
    end
  end
  assign pe_acc_0_i = m_acc00;
  assign pe_acc_1_i = m_acc01;
  assign pe_acc_2_i = m_acc10;
  assign pe_acc_3_i = m_acc11;

  typedef struct packed {
    logic [CW-1:0]        k;
    logic [3:0][MW-1:0]   a0;  // A[0][k], element 0 rightmost
    logic [3:0][MW-1:0]   a1;  // A[1][k]
    logic [3:0][MW-1:0]   b0;  // B[k][0]
    logic [3:0][MW-1:0]   b1;  // B[k][1]
    logic [3:0][AW-1:0]   c;   // {C11, C10, C01, C00}
  } vec_t;

  vec_t tv[4];
  int   cur_a0[K_MAX], cur_a1[K_MAX], cur_b0[K_MAX], cur_b1[K_MAX];

  task automatic chk(input string name, input logic [147:0] act, input logic [147:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] ctrl_vec();
    return {busy_o, a_ready_o, b_ready_o, pe_a_0_o, pe_a_1_o, pe_b_0_o, pe_b_1_o,
            pe_acc_en_o, pe_clr_o, res_valid_o, done_o};
  endfunction

  function automatic logic [147:0] ref_res(input int k);
    longint c00 = 0, c01 = 0, c10 = 0, c11 = 0;
    for (int i = 0; i < k; i++) begin
      c00 += longint'(cur_a0[i]) * cur_b0[i];
      c01 += longint'(cur_a0[i]) * cur_b1[i];
      c10 += longint'(cur_a1[i]) * cur_b0[i];
      c11 += longint'(cur_a1[i]) * cur_b1[i];
    end
    return {37'(c11), 37'(c10), 37'(c01), 37'(c00)};
  endfunction

  task automatic load_vec(input int t);
    for (int i = 0; i < K_MAX; i++) begin
      cur_a0[i] = (i < 4) ? int'($signed(tv[t].a0[i])) : 0;
      cur_a1[i] = (i < 4) ? int'($signed(tv[t].a1[i])) : 0;
      cur_b0[i] = (i < 4) ? int'($signed(tv[t].b0[i])) : 0;
      cur_b1[i] = (i < 4) ? int'($signed(tv[t].b1[i])) : 0;
    end
  endtask

  // One job: start, stream A/B (optional a_valid gap), checking edges per step,
  // then the result handshake (optionally back-pressured) and done/busy.
  task automatic run_job(input int k_cfg, input int stall_at, input int stall_len,
                         input int ready_wait, input bit always_valid,
                         output logic [147:0] data, output int valid_cyc,
                         output int steps, output int xfers);
    int keff, cyc, sent, gap, s, idx;
    bit stall, has;
    logic [4*MW-1:0] exp_edges;
    keff = (k_cfg > K_MAX) ? K_MAX : k_cfg;
    data = '0; valid_cyc = -1; steps = 0; xfers = 0; sent = 0; gap = 0;
    @(negedge clk);
    res_ready_i = (ready_wait == 0);
    start_i = 1'b1; cfg_k_i = CW'(k_cfg);
    a_valid_i = 1'b0; b_valid_i = 1'b0; a_data_i = '0; b_data_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (valid_cyc < 0 && cyc < 80) begin
      stall = (stall_len > 0) && (sent == stall_at) && (gap < stall_len);
      has   = always_valid || (sent < keff);
      idx   = (sent < keff) ? sent : 0;
      a_valid_i = has && !stall;
      b_valid_i = has;
      a_data_i  = {9'(cur_a1[idx]), 9'(cur_a0[idx])};
      b_data_i  = {9'(cur_b1[idx]), 9'(cur_b0[idx])};
      #1;
      if (cyc == 1) chk("clear_cycle", {busy_o, pe_clr_o}, 2'b11);
      if (cyc == 2) chk("clear_one_cycle", pe_clr_o, 1'b0);
      if (stall) begin
        gap++;
        chk("stall_edges", {pe_acc_en_o, pe_a_0_o, pe_a_1_o, pe_b_0_o, pe_b_1_o}, '0);
      end
      if (pe_acc_en_o) begin
        s = steps;
        exp_edges = {(s < keff) ? 9'(cur_a0[s]) : 9'd0,
                     (s >= 1 && s <= keff) ? 9'(cur_a1[s-1]) : 9'd0,
                     (s < keff) ? 9'(cur_b0[s]) : 9'd0,
                     (s >= 1 && s <= keff) ? 9'(cur_b1[s-1]) : 9'd0};
        chk("step_edges", {pe_a_0_o, pe_a_1_o, pe_b_0_o, pe_b_1_o}, exp_edges);
        steps++;
      end
      if (a_valid_i && a_ready_o) begin
        xfers++;
        sent++;
      end
      if (res_valid_o) begin
        valid_cyc = cyc;
        data = res_data_o;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    if (ready_wait > 0) begin
      for (int w = 0; w < ready_wait; w++) begin
        @(negedge clk);
        start_i = (w == 1 || w == 2); cfg_k_i = CW'(2);
        #1;
        chk("res_hold", {res_valid_o, res_data_o}, {1'b1, data});
      end
      @(negedge clk);
      start_i = 1'b0; res_ready_i = 1'b1;
    end
    @(negedge clk);
    res_ready_i = 1'b0;
    #1;
    chk("done_pulse", {done_o, busy_o, res_valid_o}, 3'b100);
    @(negedge clk);
    #1;
    chk("done_end", {done_o, busy_o}, 2'b00);
  endtask

  logic [147:0] data;
  int vcyc, nsteps, nxfers;

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0].k = 5'd2;
    tv[0].a0 = {9'd0, 9'd0, 9'd2, 9'd1};
    tv[0].a1 = {9'd0, 9'd0, 9'd4, 9'd3};
    tv[0].b0 = {9'd0, 9'd0, 9'd7, 9'd5};
    tv[0].b1 = {9'd0, 9'd0, 9'd8, 9'd6};
    tv[0].c  = {37'sd50, 37'sd43, 37'sd22, 37'sd19};
    tv[1].k = 5'd1;
    tv[1].a0 = {9'd0, 9'd0, 9'd0, 9'sd7};
    tv[1].a1 = {9'd0, 9'd0, 9'd0, -9'sd3};
    tv[1].b0 = {9'd0, 9'd0, 9'd0, 9'sd2};
    tv[1].b1 = {9'd0, 9'd0, 9'd0, -9'sd4};
    tv[1].c  = {37'sd12, -37'sd6, -37'sd28, 37'sd14};
    tv[2].k = 5'd3;
    tv[2].a0 = {9'd0, -9'sd3, 9'sd2, -9'sd1};
    tv[2].a1 = {9'd0, 9'sd6, -9'sd5, 9'sd4};
    tv[2].b0 = {9'd0, 9'sd3, -9'sd2, 9'sd1};
    tv[2].b1 = {9'd0, -9'sd3, 9'sd2, 9'sd1};
    tv[2].c  = {-37'sd24, 37'sd32, 37'sd12, -37'sd14};
    tv[3].k = 5'd4;
    tv[3].a0 = {9'h100, 9'h0FF, 9'h100, 9'h0FF};
    tv[3].a1 = {9'h0FF, 9'h0FF, 9'h100, 9'h100};
    tv[3].b0 = {9'h100, 9'h100, 9'h0FF, 9'h0FF};
    tv[3].b1 = {9'h0FF, 9'h100, 9'h0FF, 9'h100};
    tv[3].c  = {37'sd1, -37'sd261120, -37'sd261120, 37'sd1};

    // Reset held with every input active.
    rst = 1'b1; start_i = 1'b1; cfg_k_i = CW'(3); res_ready_i = 1'b1;
    a_valid_i = 1'b1; b_valid_i = 1'b1; a_data_i = 18'h15A5A; b_data_i = 18'h0A5A5;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_ctrl", ctrl_vec(), '0);
    chk("reset_data", res_data_o, '0);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_after_reset", ctrl_vec(), '0);
    a_valid_i = 1'b0; b_valid_i = 1'b0;

    // Table of clean jobs.
    for (int t = 0; t < 4; t++) begin
      load_vec(t);
      run_job(int'(tv[t].k), 0, 0, 0, 1'b0, data, vcyc, nsteps, nxfers);
      chk("tbl_result", data, tv[t].c);
      chk("tbl_valid_cycle", 148'(vcyc), 148'(int'(tv[t].k) + 5));
      chk("tbl_steps", 148'(nsteps), 148'(int'(tv[t].k) + 2));
      chk("tbl_xfers", 148'(nxfers), 148'(tv[t].k));
    end

    // Signed job with a 3-cycle a_valid gap after the first step.
    load_vec(2);
    run_job(3, 1, 3, 0, 1'b0, data, vcyc, nsteps, nxfers);
    chk("stall_result", data, tv[2].c);
    chk("stall_valid_cycle", 148'(vcyc), 148'(11));
    chk("stall_steps", 148'(nsteps), 148'(5));

    // Result back-pressure with start pulses while busy.
    load_vec(0);
    run_job(2, 0, 0, 4, 1'b0, data, vcyc, nsteps, nxfers);
    chk("bp_result", data, tv[0].c);
    chk("bp_valid_cycle", 148'(vcyc), 148'(7));

    // K = 0: streams never ready, zero result in cycle 3.
    run_job(0, 0, 0, 0, 1'b1, data, vcyc, nsteps, nxfers);
    chk("k0_result", data, '0);
    chk("k0_valid_cycle", 148'(vcyc), 148'(3));
    chk("k0_xfers", 148'(nxfers), 148'(0));
    chk("k0_steps", 148'(nsteps), 148'(0));

    // K above the limit runs exactly K_MAX transfers.
    for (int i = 0; i < K_MAX; i++) begin
      cur_a0[i] = i + 1; cur_a1[i] = -i; cur_b0[i] = 2 * i - 7; cur_b1[i] = 3 - i;
    end
    run_job(K_MAX + 3, 0, 0, 0, 1'b1, data, vcyc, nsteps, nxfers);
    chk("clamp_xfers", 148'(nxfers), 148'(K_MAX));
    chk("clamp_steps", 148'(nsteps), 148'(K_MAX + 2));
    chk("clamp_valid_cycle", 148'(vcyc), 148'(K_MAX + 5));
    chk("clamp_result", data, ref_res(K_MAX));

    // Reset during FEED step 1, then a clean K=2 job.
    load_vec(0);
    @(negedge clk);
    res_ready_i = 1'b1; start_i = 1'b1; cfg_k_i = CW'(2);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    a_data_i = {9'(cur_a1[0]), 9'(cur_a0[0])}; b_data_i = {9'(cur_b1[0]), 9'(cur_b0[0])};
    @(negedge clk);
    a_data_i = {9'(cur_a1[1]), 9'(cur_a0[1])}; b_data_i = {9'(cur_b1[1]), 9'(cur_b0[1])};
    #1;
    chk("mid_step1_active", {pe_acc_en_o, a_ready_o}, 2'b11);
    rst = 1'b1;
    #1;
    chk("mid_reset_ctrl", ctrl_vec(), '0);
    chk("mid_reset_data", res_data_o, '0);
    @(negedge clk);
    rst = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_reset_idle", busy_o, 1'b0);
    run_job(2, 0, 0, 0, 1'b0, data, vcyc, nsteps, nxfers);
    chk("post_reset_result", data, tv[0].c);
    chk("post_reset_valid_cycle", 148'(vcyc), 148'(7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
